// File: rtl/bcd_countdown_timer_if.sv
// Keypad/control inputs and BCD display/status outputs of the microwave countdown core.
// The master side is the controller or bench; the slave side is the timer.
interface bcd_countdown_timer_if;
  logic       Load;
  logic [3:0] D;
  logic       Clear;
  logic       Start;
  logic       Stop;
  logic       DoorClosed;
  logic [3:0] Minutes;
  logic [3:0] TenSec;
  logic [3:0] Sec;
  logic       Running;
  logic       Zero;
  logic       Done;

  modport master (
    output Load, D, Clear, Start, Stop, DoorClosed,
    input  Minutes, TenSec, Sec, Running, Zero, Done
  );

  modport slave (
    input  Load, D, Clear, Start, Stop, DoorClosed,
    output Minutes, TenSec, Sec, Running, Zero, Done
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Three-digit BCD countdown (M:TS) with keypad entry, one-second prescaler,
// pause/resume on Stop or door open, and a one-cycle Done pulse at 0:00.
module bcd_countdown_timer #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic                    clk,
  input  logic                    reset,
  bcd_countdown_timer_if.slave    bus
);

  localparam int             PW   = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0]  LAST = PW'(TICKS_PER_SEC - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  logic [1:0]    state_q, state_n;
  logic [3:0]    min_q, ten_q, sec_q;
  logic [3:0]    min_n, ten_n, sec_n;
  logic [PW-1:0] presc_q, presc_n;
  logic          running_q;
  logic          done_q, done_n;
  logic          zero;
  logic          tick;
  logic [11:0]   dec_time;

  // Borrow chain wraps seconds to 9 and tens to 5, so 1:00 -> 0:59 while an
  // entered 0:90 simply counts down to 0:89.
  function automatic logic [11:0] bcd_dec(input logic [11:0] t);
    logic [3:0] m, ts, s;
    {m, ts, s} = t;
    if (s != 4'd0) begin
      s = s - 4'd1;
    end else begin
      s = 4'd9;
      if (ts != 4'd0) begin
        ts = ts - 4'd1;
      end else begin
        ts = 4'd5;
        m  = m - 4'd1;
      end
    end
    return {m, ts, s};
  endfunction

  assign zero     = (min_q == 4'd0) && (ten_q == 4'd0) && (sec_q == 4'd0);
  assign tick     = (presc_q == LAST);
  assign dec_time = bcd_dec({min_q, ten_q, sec_q});

  always_comb begin
    state_n = state_q;
    min_n   = min_q;
    ten_n   = ten_q;
    sec_n   = sec_q;
    presc_n = presc_q;
    done_n  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.Stop) begin
          {min_n, ten_n, sec_n} = 12'd0;
        end else if (bus.Start && bus.DoorClosed && !zero) begin
          state_n = S_RUN;
          presc_n = '0;
        end else if (bus.Clear) begin
          {min_n, ten_n, sec_n} = 12'd0;
        end else if (bus.Load && (bus.D <= 4'd9)) begin
          {min_n, ten_n, sec_n} = {ten_q, sec_q, bus.D};
        end
      end
      S_RUN: begin
        // Pausing freezes the prescaler so a resume finishes the partial second.
        if (bus.Stop || !bus.DoorClosed) begin
          state_n = S_PAUSE;
        end else if (tick) begin
          presc_n = '0;
          {min_n, ten_n, sec_n} = dec_time;
          if (dec_time == 12'd0) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
        end else begin
          presc_n = presc_q + 1'b1;
        end
      end
      S_PAUSE: begin
        if (bus.Stop) begin
          state_n = S_IDLE;
          presc_n = '0;
          {min_n, ten_n, sec_n} = 12'd0;
        end else if (bus.Start && bus.DoorClosed) begin
          state_n = S_RUN;
        end
      end
      default: begin
        state_n = S_IDLE;
        presc_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      min_q     <= 4'd0;
      ten_q     <= 4'd0;
      sec_q     <= 4'd0;
      presc_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      min_q     <= min_n;
      ten_q     <= ten_n;
      sec_q     <= sec_n;
      presc_q   <= presc_n;
      running_q <= (state_n == S_RUN);
      done_q    <= done_n;
    end
  end

  assign bus.Minutes = min_q;
  assign bus.TenSec  = ten_q;
  assign bus.Sec     = sec_q;
  assign bus.Running = running_q;
  assign bus.Zero    = zero;
  assign bus.Done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer with a 4-cycle second.
module tb_bcd_countdown_timer;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  bcd_countdown_timer_if bus ();

  bcd_countdown_timer #(.TICKS_PER_SEC(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_digit(input logic [3:0] d);
    bus.Load = 1'b1;
    bus.D    = d;
    step();
    bus.Load = 1'b0;
    bus.D    = 4'd0;
  endtask

  task automatic press_start();
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
  endtask

  task automatic press_stop();
    bus.Stop = 1'b1;
    step();
    bus.Stop = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++;
    if ({bus.Minutes, bus.TenSec, bus.Sec} !== 12'h000 || bus.Running !== 1'b0 ||
        bus.Done !== 1'b0 || bus.Zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got %h run=%b done=%b zero=%b expected 000 0 0 1",
               {bus.Minutes, bus.TenSec, bus.Sec}, bus.Running, bus.Done, bus.Zero);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_load();
    do_reset();
    load_digit(4'd1);
    load_digit(4'd3);
    checks++;
    if ({bus.Minutes, bus.TenSec, bus.Sec} !== 12'h013) begin
      errors++;
      $display("FAIL load_two got %h expected 013", {bus.Minutes, bus.TenSec, bus.Sec});
    end
    load_digit(4'd0);
    checks++;
    if ({bus.Minutes, bus.TenSec, bus.Sec} !== 12'h130 || bus.Zero !== 1'b0) begin
      errors++;
      $display("FAIL load_three got %h zero=%b expected 130 0",
               {bus.Minutes, bus.TenSec, bus.Sec}, bus.Zero);
    end
    load_digit(4'd12);
    checks++;
    if ({bus.Minutes, bus.TenSec, bus.Sec} !== 12'h130) begin
      errors++;
      $display("FAIL load_invalid got %h expected 130", {bus.Minutes, bus.TenSec, bus.Sec});
    end
    bus.Clear = 1'b1;
    step();
    bus.Clear = 1'b0;
    checks++;
    if ({bus.Minutes, bus.TenSec, bus.Sec} !== 12'h000 || bus.Zero !== 1'b1) begin
      errors++;
      $display("FAIL clear got %h zero=%b expected 000 1",
               {bus.Minutes, bus.TenSec, bus.Sec}, bus.Zero);
    end
  endtask

  task automatic test_countdown();
    int done_seen;
    do_reset();
    load_digit(4'd0);
    load_digit(4'd0);
    load_digit(4'd2);
    press_start();
    checks++;
    if (bus.Running !== 1'b1) begin
      errors++;
      $display("FAIL start_running got %b expected 1", bus.Running);
    end
    done_seen = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (bus.Done === 1'b1) done_seen++;
      if (c == 3) begin
        checks++;
        if ({bus.Minutes, bus.TenSec, bus.Sec} !== 12'h002) begin
          errors++;
          $display("FAIL before_tick got %h expected 002", {bus.Minutes, bus.TenSec, bus.Sec});
        end
      end
      if (c == 4) begin
        checks++;
        if ({bus.Minutes, bus.TenSec, bus.Sec} !== 12'h001 || bus.Done !== 1'b0) begin
          errors++;
          $display("FAIL first_tick got %h done=%b expected 001 0",
                   {bus.Minutes, bus.TenSec, bus.Sec}, bus.Done);
        end
      end
    end
    checks++;
    if ({bus.Minutes, bus.TenSec, bus.Sec} !== 12'h000 || bus.Done !== 1'b1 ||
        bus.Running !== 1'b0 || bus.Zero !== 1'b1) begin
      errors++;
      $display("FAIL finish got %h done=%b run=%b zero=%b expected 000 1 0 1",
               {bus.Minutes, bus.TenSec, bus.Sec}, bus.Done, bus.Running, bus.Zero);
    end
    step();
    checks++;
    if (bus.Done !== 1'b0 || done_seen != 1) begin
      errors++;
      $display("FAIL done_pulse got done=%b pulses=%0d expected 0 and 1", bus.Done, done_seen);
    end
    press_start();
    checks++;
    if (bus.Running !== 1'b0) begin
      errors++;
      $display("FAIL start_at_zero got run=%b expected 0", bus.Running);
    end
  endtask

  task automatic test_borrow();
    do_reset();
    load_digit(4'd1);
    load_digit(4'd0);
    load_digit(4'd0);
    press_start();
    repeat (4) step();
    checks++;
    if ({bus.Minutes, bus.TenSec, bus.Sec} !== 12'h059) begin
      errors++;
      $display("FAIL borrow_minute got %h expected 059", {bus.Minutes, bus.TenSec, bus.Sec});
    end
    press_stop();
    press_stop();
    load_digit(4'd9);
    load_digit(4'd0);
    press_start();
    repeat (4) step();
    checks++;
    if ({bus.Minutes, bus.TenSec, bus.Sec} !== 12'h089) begin
      errors++;
      $display("FAIL non_normal got %h expected 089", {bus.Minutes, bus.TenSec, bus.Sec});
    end
  endtask

  task automatic test_door_pause_and_cancel();
    do_reset();
    load_digit(4'd5);
    press_start();
    repeat (2) step();
    bus.DoorClosed = 1'b0;
    repeat (3) step();
    checks++;
    if ({bus.Minutes, bus.TenSec, bus.Sec} !== 12'h005 || bus.Running !== 1'b0) begin
      errors++;
      $display("FAIL door_pause got %h run=%b expected 005 0",
               {bus.Minutes, bus.TenSec, bus.Sec}, bus.Running);
    end
    bus.DoorClosed = 1'b1;
    press_start();
    step();
    checks++;
    if ({bus.Minutes, bus.TenSec, bus.Sec} !== 12'h005 || bus.Running !== 1'b1) begin
      errors++;
      $display("FAIL resume_hold got %h run=%b expected 005 1",
               {bus.Minutes, bus.TenSec, bus.Sec}, bus.Running);
    end
    step();
    checks++;
    if ({bus.Minutes, bus.TenSec, bus.Sec} !== 12'h004) begin
      errors++;
      $display("FAIL resume_prescaler got %h expected 004", {bus.Minutes, bus.TenSec, bus.Sec});
    end
    press_stop();
    checks++;
    if ({bus.Minutes, bus.TenSec, bus.Sec} !== 12'h004 || bus.Running !== 1'b0) begin
      errors++;
      $display("FAIL stop_pause got %h run=%b expected 004 0",
               {bus.Minutes, bus.TenSec, bus.Sec}, bus.Running);
    end
    press_stop();
    checks++;
    if ({bus.Minutes, bus.TenSec, bus.Sec} !== 12'h000 || bus.Done !== 1'b0 || bus.Zero !== 1'b1) begin
      errors++;
      $display("FAIL cancel got %h done=%b zero=%b expected 000 0 1",
               {bus.Minutes, bus.TenSec, bus.Sec}, bus.Done, bus.Zero);
    end
  endtask

  task automatic test_stop_on_tick();
    do_reset();
    load_digit(4'd3);
    press_start();
    repeat (3) step();
    press_stop();
    checks++;
    if ({bus.Minutes, bus.TenSec, bus.Sec} !== 12'h003 || bus.Running !== 1'b0) begin
      errors++;
      $display("FAIL stop_vs_tick got %h run=%b expected 003 0",
               {bus.Minutes, bus.TenSec, bus.Sec}, bus.Running);
    end
    press_start();
    step();
    checks++;
    if ({bus.Minutes, bus.TenSec, bus.Sec} !== 12'h002) begin
      errors++;
      $display("FAIL tick_after_resume got %h expected 002", {bus.Minutes, bus.TenSec, bus.Sec});
    end
  endtask

  task automatic test_async_reset();
    int done_seen;
    do_reset();
    load_digit(4'd3);
    press_start();
    repeat (2) step();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.Minutes, bus.TenSec, bus.Sec} !== 12'h000 || bus.Running !== 1'b0 ||
        bus.Zero !== 1'b1 || bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got %h run=%b zero=%b done=%b expected 000 0 1 0",
               {bus.Minutes, bus.TenSec, bus.Sec}, bus.Running, bus.Zero, bus.Done);
    end
    done_seen = 0;
    repeat (2) begin
      step();
      if (bus.Done === 1'b1) done_seen++;
    end
    reset = 1'b0;
    repeat (6) begin
      step();
      if (bus.Done === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0 || bus.Running !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done got pulses=%0d run=%b expected 0 0", done_seen, bus.Running);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.Load = 1'b0;
    bus.D = 4'd0;
    bus.Clear = 1'b0;
    bus.Start = 1'b0;
    bus.Stop = 1'b0;
    bus.DoorClosed = 1'b1;
    reset = 1'b0;
    test_reset();
    test_load();
    test_countdown();
    test_borrow();
    test_door_pause_and_cancel();
    test_stop_on_tick();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
